// File: rtl/alu_exec_unit.sv
// Handshaked ALU with single-cycle logic/arith/shift ops and a 32-cycle iterative shift-add multiplier.
// One request in flight; results are held in DONE until the consumer accepts them.
`timescale 1ns/1ps
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             ZeroFlag,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_MUL = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state, state_next;
  logic             ready_q;
  logic             accept;
  logic             mul_last;
  logic [CW-1:0]    mul_cnt;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] alu_result;

  // ready_q keeps in_ready low while reset is held and releases it on the first edge after.
  assign in_ready  = ready_q && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign mul_last  = (mul_cnt == CW'(WIDTH - 1));
  assign acc_step  = mplier[0] ? acc + mcand : acc;

  always_comb begin
    alu_result = '0;
    case (ALU_Sel)
      OP_AND:  alu_result = A & B;
      OP_OR:   alu_result = A | B;
      OP_ADD:  alu_result = A + B;
      OP_SLL:  alu_result = A << B[CW-1:0];
      OP_SUB:  alu_result = A - B;
      OP_SRL:  alu_result = A >> B[CW-1:0];
      OP_XOR:  alu_result = A ^ B;
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (ALU_Sel == OP_MUL) ? MUL : DONE;
      MUL:     if (mul_last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Multiplier consumes one bit of B per cycle, LSB first; the flag only ever sees the final product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q  <= 1'b0;
      ALU_Out  <= '0;
      ZeroFlag <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      mul_cnt  <= '0;
    end else begin
      ready_q <= 1'b1;
      if (accept) begin
        if (ALU_Sel == OP_MUL) begin
          acc     <= '0;
          mcand   <= A;
          mplier  <= B;
          mul_cnt <= '0;
        end else begin
          ALU_Out  <= alu_result;
          ZeroFlag <= (alu_result == '0);
        end
      end else if (state == MUL) begin
        acc     <= acc_step;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        mul_cnt <= mul_cnt + CW'(1);
        if (mul_last) begin
          ALU_Out  <= acc_step;
          ZeroFlag <= (acc_step == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed scoreboard bench for alu_exec_unit: expected results are queued at issue
// and popped when out_valid appears; latency is counted in cycles from the accept edge.
`timescale 1ns/1ps
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  ALU_Sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] ALU_Out;
  logic        ZeroFlag;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Out(ALU_Out), .ZeroFlag(ZeroFlag), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Waits (bounded) for in_ready, presents one request for a single accept edge, then scrambles inputs.
  task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                           output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) return;
    A = a; B = b; ALU_Sel = sel; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom; B = $urandom; ALU_Sel = 4'($urandom);
    ok = 1'b1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    compared++;
    if ({in_ready, out_valid, busy, ZeroFlag} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got rdy/vld/busy/zf=%b required 0000",
               {in_ready, out_valid, busy, ZeroFlag});
    end
    compared++;
    if (ALU_Out !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_out: got %h required 00000000", ALU_Out);
    end
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_release_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_add();
    bit ok; int lat; exp_t e;
    out_ready = 1'b1;
    sb.push_back('{32'd8, 1'b0});
    drive_req(32'd5, 32'd3, 4'b0010, ok);
    compared++;
    if (!ok) begin mismatched++; $display("[TB] FAIL add_accept: got no accept required accept"); end
    wait_valid(lat);
    compared++;
    if (lat !== 1) begin mismatched++; $display("[TB] FAIL add_latency: got %0d required 1", lat); end
    e = sb.pop_front();
    compared++;
    if (ALU_Out !== e.res || ZeroFlag !== e.zero) begin
      mismatched++;
      $display("[TB] FAIL add_result: got %h/%b required %h/%b", ALU_Out, ZeroFlag, e.res, e.zero);
    end
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL add_return_idle: got rdy/vld=%b%b required 10", in_ready, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_sub_zero();
    bit ok; int lat; exp_t e;
    logic [31:0] av[2] = '{32'd5, 32'd9};
    logic [31:0] bv[2] = '{32'd5, 32'd4};
    sb.push_back('{32'd0, 1'b1});
    sb.push_back('{32'd5, 1'b0});
    for (int i = 0; i < 2; i++) begin
      drive_req(av[i], bv[i], 4'b0100, ok);
      wait_valid(lat);
      e = sb.pop_front();
      compared++;
      if (!ok || lat !== 1 || ALU_Out !== e.res || ZeroFlag !== e.zero) begin
        mismatched++;
        $display("[TB] FAIL sub_%0d: got ok=%b lat=%0d %h/%b required lat=1 %h/%b",
                 i, ok, lat, ALU_Out, ZeroFlag, e.res, e.zero);
      end
      release_result();
    end
  endtask

  task automatic test_mul();
    bit ok; int lat; bit bad; exp_t e;
    logic [31:0] av[2] = '{32'd3, 32'hFFFF_FFFF};
    logic [31:0] bv[2] = '{32'd2, 32'hFFFF_FFFF};
    sb.push_back('{32'd6, 1'b0});
    sb.push_back('{32'h0000_0001, 1'b0});
    for (int i = 0; i < 2; i++) begin
      drive_req(av[i], bv[i], 4'b0110, ok);
      lat = 1; bad = 1'b0;
      while (!out_valid && lat < 100) begin
        if (busy !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
        @(negedge clk);
        lat++;
      end
      compared++;
      if (!ok || bad || busy !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL mul_%0d_busy: got ok=%b bad=%b busy=%b required ok=1 bad=0 busy=1",
                 i, ok, bad, busy);
      end
      compared++;
      if (lat !== 33) begin mismatched++; $display("[TB] FAIL mul_%0d_latency: got %0d required 33", i, lat); end
      e = sb.pop_front();
      compared++;
      if (ALU_Out !== e.res || ZeroFlag !== e.zero) begin
        mismatched++;
        $display("[TB] FAIL mul_%0d_result: got %h/%b required %h/%b", i, ALU_Out, ZeroFlag, e.res, e.zero);
      end
      release_result();
    end
  endtask

  task automatic test_shift_backpressure();
    bit ok; int lat; bit bad; exp_t e;
    sb.push_back('{32'd4, 1'b0});
    drive_req(32'h10, 32'h22, 4'b0101, ok);
    wait_valid(lat);
    e = sb.pop_front();
    compared++;
    if (!ok || lat !== 1 || ALU_Out !== e.res || ZeroFlag !== e.zero) begin
      mismatched++;
      $display("[TB] FAIL srl_result: got ok=%b lat=%0d %h/%b required lat=1 %h/%b",
               ok, lat, ALU_Out, ZeroFlag, e.res, e.zero);
    end
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0] ? 1'b0 : 1'b1;
      A = $urandom; B = $urandom; ALU_Sel = 4'b0010;
      @(negedge clk);
      if (ALU_Out !== e.res || ZeroFlag !== e.zero || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
    end
    in_valid = 1'b0;
    compared++;
    if (bad) begin mismatched++; $display("[TB] FAIL backpressure_hold: got unstable hold required stable"); end
    release_result();
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL backpressure_release: got vld/rdy=%b%b required 01", out_valid, in_ready);
    end
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL ignored_pulses: got out_valid=1 required 0"); end
  endtask

  task automatic test_logic_illegal();
    bit ok; int lat; exp_t e;
    logic [3:0]  sel[7] = '{4'b1010, 4'b0000, 4'b0001, 4'b0111, 4'b0011, 4'b0010, 4'b0100};
    logic [31:0] av[7]  = '{32'h1234, 32'h0F, 32'h0F, 32'h0F, 32'h1, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] bv[7]  = '{32'h5678, 32'hF0, 32'hF0, 32'hF0, 32'hFFFF_FFE5, 32'h1, 32'h1};
    sb.push_back('{32'h0, 1'b1});
    sb.push_back('{32'h0, 1'b1});
    sb.push_back('{32'hFF, 1'b0});
    sb.push_back('{32'hFF, 1'b0});
    sb.push_back('{32'h20, 1'b0});
    sb.push_back('{32'h0, 1'b1});
    sb.push_back('{32'hFFFF_FFFF, 1'b0});
    for (int i = 0; i < 7; i++) begin
      drive_req(av[i], bv[i], sel[i], ok);
      wait_valid(lat);
      e = sb.pop_front();
      compared++;
      if (!ok || lat !== 1 || ALU_Out !== e.res || ZeroFlag !== e.zero) begin
        mismatched++;
        $display("[TB] FAIL op_sel%b: got ok=%b lat=%0d %h/%b required lat=1 %h/%b",
                 sel[i], ok, lat, ALU_Out, ZeroFlag, e.res, e.zero);
      end
      release_result();
    end
  endtask

  task automatic test_reset_mid_mul();
    bit ok; int lat; bit seen; exp_t e;
    drive_req(32'd7, 32'd9, 4'b0110, ok);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || ALU_Out !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL mid_mul_reset: got vld/rdy/busy=%b%b%b out=%h required 000 00000000",
               out_valid, in_ready, busy, ALU_Out);
    end
    repeat (2) @(negedge clk);
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_mul_reset_hold: got vld/rdy=%b%b required 00", out_valid, in_ready);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    compared++;
    if (seen) begin mismatched++; $display("[TB] FAIL aborted_mul: got out_valid=1 required 0"); end
    sb.push_back('{32'd2, 1'b0});
    drive_req(32'd1, 32'd1, 4'b0010, ok);
    wait_valid(lat);
    e = sb.pop_front();
    compared++;
    if (!ok || lat !== 1 || ALU_Out !== e.res || ZeroFlag !== e.zero) begin
      mismatched++;
      $display("[TB] FAIL post_reset_add: got ok=%b lat=%0d %h/%b required lat=1 %h/%b",
               ok, lat, ALU_Out, ZeroFlag, e.res, e.zero);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_zero();
    test_mul();
    test_shift_backpressure();
    test_logic_illegal();
    test_reset_mid_mul();
    compared++;
    if (sb.size() !== 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d left required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: WIDTH, 32, datapath width; SHALL be 32 in this core.
REQ-002 Ports SHALL be:
clk  in  1  single clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request
A  in  WIDTH  operand A
B  in  WIDTH  operand B
ALU_Sel  in  4  operation select
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
ALU_Out  out  WIDTH  registered result
ZeroFlag  out  1  registered (ALU_Out == 0)
busy  out  1  high in MUL or DONE state

Function
REQ-003 The request handshake SHALL complete on a rising edge with in_valid=1 and in_ready=1. A, B and ALU_Sel SHALL be sampled only on that edge. Later input changes SHALL be ignored.
REQ-004 The FSM SHALL have three states: IDLE, MUL and DONE.
REQ-005 in_ready SHALL be 1 only in IDLE. Only one request SHALL be in flight. in_valid outside IDLE SHALL be ignored.
REQ-006 IDLE with acceptance: ALU_Sel=0110 SHALL enter MUL. Any other ALU_Sel SHALL register the result and ZeroFlag and enter DONE.
REQ-007 Encodings:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0011 SLL
- 0100 SUB
- 0101 SRL
- 0110 MUL
- 0111 XOR
- all others: result 0, ZeroFlag 1, handled as a non-MUL op.
REQ-008 ADD and SUB SHALL wrap modulo 2^WIDTH. No carry or overflow output SHALL exist.
REQ-009 SLL and SRL SHALL shift A by B[4:0] only. B[31:5] SHALL be ignored. SRL SHALL zero-fill.
REQ-010 MUL SHALL be an iterative shift-add over exactly WIDTH cycles, one bit of B per cycle, LSB first, with a 5-bit counter. It SHALL produce the low WIDTH bits of unsigned A*B.
REQ-011 After the WIDTH-th MUL iteration, the unit SHALL register the result and ZeroFlag and enter DONE.
REQ-012 Latency, counted from the acceptance edge to the first cycle out_valid=1:
- non-MUL: 1 cycle
- MUL: WIDTH+1 = 33 cycles.
REQ-013 out_valid SHALL be 1 exactly in DONE.
REQ-014 While out_valid=1 and out_ready=0, ALU_Out and ZeroFlag SHALL be held stable. There is no timeout.
REQ-015 On an edge with out_valid=1 and out_ready=1, the unit SHALL return to IDLE, and in_ready SHALL be 1 in the next cycle. No same-cycle accept-and-complete SHALL occur.
REQ-016 ALU_Out and ZeroFlag SHALL keep their last value in IDLE and MUL. Consumers SHALL qualify them with out_valid.
REQ-017 ZeroFlag SHALL be computed from the final registered result, never from intermediate MUL partial sums.

Reset
REQ-018 While rst=1, asynchronously:
- state SHALL be IDLE.
- in_ready, out_valid, busy and ZeroFlag SHALL be 0.
- ALU_Out, the MUL counter and the accumulators SHALL be 0.
REQ-019 After rst deasserts, in_ready SHALL be 1 from the first clock edge.
REQ-020 Reset asserted in MUL or DONE SHALL abort the operation. No out_valid SHALL appear for the aborted request.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- ADD: A=5, B=3, Sel=0010, out_ready=1 -> out_valid one cycle after accept, ALU_Out=8, ZeroFlag=0, then in_ready=1.
- SUB zero: A=5, B=5, Sel=0100 -> ALU_Out=0, ZeroFlag=1. Then A=9, B=4 -> ALU_Out=5, ZeroFlag=0.
- MUL: A=3, B=2, Sel=0110 -> busy=1 and in_ready=0 throughout, out_valid exactly 33 cycles after accept, ALU_Out=6. Then A=B=0xFFFFFFFF -> ALU_Out=0x00000001.
- Shift and backpressure: A=0x10, B=0x22, Sel=0101 -> ALU_Out=4. Hold out_ready=0 for 5 cycles -> ALU_Out stable, in_ready=0, in_valid pulses ignored; the response completes on the first out_ready=1 edge.
- Illegal and logic ops: Sel=1010 -> ALU_Out=0, ZeroFlag=1. AND 0x0F/0xF0 -> 0 with ZeroFlag=1. OR and XOR 0x0F/0xF0 -> 0xFF.
- Reset mid-MUL: assert rst 10 cycles after a MUL accept -> out_valid=0 and in_ready=0 during reset. After release, ADD 1+1 -> 2 with 1-cycle latency.
